// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I-subset controller and its datapath:
// FSM state codes, opcodes, ALU op/control codes and mux-select encodings.
package multicycle_ctrl_pkg;

  localparam int unsigned STATE_W = 4;
  typedef logic [STATE_W-1:0] state_t;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_HALT     = 4'd11;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_ctrl_alu_dec.sv
// ALU decoder: maps the FSM's aluOp plus instruction function fields to aluControl.
module mc_alu_dec
  import multicycle_ctrl_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] func3_i,
  input  logic       func7_i,
  input  logic       op5_i,
  output logic [2:0] alu_control_o
);

  // funct7[5] only selects sub for R-type; addi ignores it since op[5]=0
  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNC: begin
        case (func3_i)
          3'b000:  alu_control_o = (op5_i & func7_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle RV32I-subset datapath (lw, sw, R, I, beq, jal).
// Define MULTICYCLE_MEM_WAIT_EN to add memReady wait-state handling on memory states.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
`ifdef MULTICYCLE_MEM_WAIT_EN
  input  logic       memReady,
`endif
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic       func7,
  input  logic       zero,
  output logic       pcWrite,
  output logic       adrSrc,
  output logic       memWrite,
  output logic       irWrite,
  output logic [1:0] resultSrc,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic       regWrite,
  output logic [2:0] aluControl,
  output logic [1:0] immSrc,
  output logic       instrDone,
  output logic       illegal
);

  state_t     state_q, state_d;
  logic       mem_rdy;
  logic       pc_update, branch, ir_write_en, mem_write_en, reg_write_en, done, halted;
  logic [1:0] alu_op;

`ifdef MULTICYCLE_MEM_WAIT_EN
  assign mem_rdy = memReady;
`else
  assign mem_rdy = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state and per-state datapath controls
  always_comb begin
    state_d      = state_q;
    pc_update    = 1'b0;
    branch       = 1'b0;
    ir_write_en  = 1'b0;
    mem_write_en = 1'b0;
    reg_write_en = 1'b0;
    done         = 1'b0;
    halted       = 1'b0;
    adrSrc       = 1'b0;
    resultSrc    = RES_ALUOUT;
    aluSrcA      = SRCA_PC;
    aluSrcB      = SRCB_RS2;
    alu_op       = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        aluSrcB   = SRCB_FOUR;
        resultSrc = RES_ALU;
        if (mem_rdy) begin
          ir_write_en = 1'b1;
          pc_update   = 1'b1;
          state_d     = S_DECODE;
        end
      end
      S_DECODE: begin
        aluSrcA = SRCA_OLDPC;
        aluSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_IMM;
        state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adrSrc = 1'b1;
        if (mem_rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        resultSrc    = RES_MEMDATA;
        reg_write_en = 1'b1;
        done         = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        adrSrc = 1'b1;
        if (mem_rdy) begin
          mem_write_en = 1'b1;
          done         = 1'b1;
          state_d      = S_FETCH;
        end
      end
      S_EXECR: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_RS2;
        alu_op  = ALUOP_FUNC;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNC;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_en = 1'b1;
        done         = 1'b1;
        state_d      = S_FETCH;
      end
      S_BEQ: begin
        aluSrcA = SRCA_RS1;
        aluSrcB = SRCB_RS2;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
        done    = 1'b1;
        state_d = S_FETCH;
      end
      // Jump target was computed into ALUOut during DECODE; ALU now forms the link PC+4
      S_JAL: begin
        aluSrcA   = SRCA_OLDPC;
        aluSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_HALT:  halted = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

  // Immediate format follows the opcode in every state
  always_comb begin
    case (op)
      OP_SW:   immSrc = IMM_S;
      OP_BEQ:  immSrc = IMM_B;
      OP_JAL:  immSrc = IMM_J;
      default: immSrc = IMM_I;
    endcase
  end

  mc_alu_dec u_alu_dec (
    .alu_op_i      (alu_op),
    .func3_i       (func3),
    .func7_i       (func7),
    .op5_i         (op[5]),
    .alu_control_o (aluControl)
  );

  // Reset is synchronous, so the state may still be mid-instruction: mask every enable
  assign pcWrite   = ~reset & (pc_update | (branch & zero));
  assign irWrite   = ~reset & ir_write_en;
  assign memWrite  = ~reset & mem_write_en;
  assign regWrite  = ~reset & reg_write_en;
  assign instrDone = ~reset & done;
  assign illegal   = ~reset & halted;

endmodule
